// File: rtl/noise_pwm_dac.sv
// noise_pwm_dac: once per frame latches a volume-scaled noise sample as the
// duty value and turns it into a registered PWM bit stream.
module noise_pwm_dac #(
   parameter int PWM_BITS = 8,
   parameter int DIV      = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [16:0]         noise,
   input  logic                enable,
   input  logic [3:0]          volume,
   output logic                pwm_out,
   output logic                sample_strobe,
   output logic [PWM_BITS-1:0] duty,
   output logic                busy
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t              state;
   state_t              state_next;
   logic [PW-1:0]       presc;
   logic [PWM_BITS-1:0] pcnt;
   logic                presc_last;
   logic                frame_end;
   logic [PWM_BITS+3:0] sample_ext;
   logic [PWM_BITS+3:0] volume_ext;
   logic [PWM_BITS+3:0] product;
   logic                unused_bits;

   // Scaling uses the top PWM_BITS of the 16-bit sample; the low nibble of the
   // product is dropped so volume 15 stays just below full scale.
   always_comb begin
      presc_last = (presc == PW'(DIV - 1));
      frame_end  = (state == RUN) && presc_last && (&pcnt);
      sample_ext = '0;
      sample_ext[PWM_BITS-1:0] = noise[15:16-PWM_BITS];
      volume_ext = '0;
      volume_ext[3:0] = volume;
      product     = sample_ext * volume_ext;
      unused_bits = ^{noise, product[3:0]};
   end

   always_comb begin
      state_next    = state;
      sample_strobe = (state == LOAD);
      busy          = (state != IDLE);
      case (state)
         IDLE: if (enable) state_next = LOAD;
         LOAD: state_next = RUN;
         RUN:  if (frame_end) state_next = enable ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Counters only move in RUN; at frame end both wrap to zero naturally,
   // so LOAD and IDLE always see them cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         presc   <= '0;
         pcnt    <= '0;
         duty    <= '0;
         pwm_out <= 1'b0;
      end else begin
         state   <= state_next;
         pwm_out <= (state == RUN) && (pcnt < duty);
         if (state == LOAD) duty <= product[PWM_BITS+3:4];
         if (state == RUN) begin
            presc <= presc_last ? '0 : presc + PW'(1);
            if (presc_last) pcnt <= pcnt + PWM_BITS'(1);
         end else begin
            presc <= '0;
            pcnt  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_noise_pwm_dac.sv
// Self-checking bench for noise_pwm_dac (PWM_BITS=8, DIV=4) using a queue of
// expected duty values pushed when a sample is set up and popped per frame.
module tb_noise_pwm_dac;

   localparam int PWM_BITS  = 8;
   localparam int DIV       = 4;
   localparam int FRAME_LEN = (1 << PWM_BITS) * DIV + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic [16:0] noise;
   logic        enable;
   logic [3:0]  volume;
   logic        pwm_out;
   logic        sample_strobe;
   logic [7:0]  duty;
   logic        busy;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   noise_pwm_dac #(.PWM_BITS(PWM_BITS), .DIV(DIV)) dut (
      .clk(clk), .reset(reset), .noise(noise), .enable(enable), .volume(volume),
      .pwm_out(pwm_out), .sample_strobe(sample_strobe), .duty(duty), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model_duty(input logic [16:0] n, input logic [3:0] v);
      int prod;
      prod = int'(n[15:8]) * int'(v);
      return 8'(prod / 16);
   endfunction

   // Reset for two cycles, then release with the given inputs applied.
   task automatic do_reset(input logic [16:0] n, input logic [3:0] v, input logic e);
      @(negedge clk);
      reset = 1'b1;
      noise = n; volume = v; enable = e;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Finds a strobe (or uses the current one), then runs to the next strobe or
   // to idle; new inputs are applied 100 cycles into the frame.
   task automatic measure_frame(input logic [16:0] nn, input logic [3:0] nv, input logic ne,
                                output int gap, output int highs,
                                output logic [7:0] d_start, output logic [7:0] d_end,
                                output bit ok);
      ok = 1'b0; gap = 0; highs = 0; d_start = '0; d_end = '0;
      for (int n = 0; n < 3000 && !sample_strobe; n++) @(negedge clk);
      if (!sample_strobe) return;
      highs = int'(pwm_out);
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         gap++;
         if (gap == 1) d_start = duty;
         if (gap == 100) begin
            noise = nn; volume = nv; enable = ne;
         end
         if (sample_strobe || !busy) begin
            ok = 1'b1;
            break;
         end
         highs += int'(pwm_out);
         d_end = duty;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b1; noise = 17'h0FFFF; volume = 4'd15;
      repeat (3) @(negedge clk);
      total += 4;
      if (pwm_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_pwm: got %b expected 0", pwm_out); end
      if (duty !== 8'd0) begin bad++; $display("[TB] FAIL reset_duty: got %0d expected 0", duty); end
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      if (sample_strobe !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobe: got %b expected 0", sample_strobe); end
   endtask

   task automatic test_nominal;
      int gap, highs; logic [7:0] ds, de, e; bit ok;
      do_reset(17'h08000, 4'd15, 1'b1);
      exp_q.push_back(8'd120);
      for (int f = 0; f < 2; f++) begin
         if (f == 0) exp_q.push_back(8'd120);
         measure_frame(17'h08000, 4'd15, (f == 0), gap, highs, ds, de, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         total += 4;
         if (!ok) begin bad++; $display("[TB] FAIL nominal_timeout: got 0 expected 1"); end
         if (gap !== FRAME_LEN) begin bad++; $display("[TB] FAIL nominal_period: got %0d expected %0d", gap, FRAME_LEN); end
         if (ds !== e) begin bad++; $display("[TB] FAIL nominal_duty: got %0d expected %0d", ds, e); end
         if (highs !== 480) begin bad++; $display("[TB] FAIL nominal_highs: got %0d expected 480", highs); end
      end
   endtask

   task automatic test_volume_zero;
      int gap, highs; logic [7:0] ds, de, e; bit ok;
      do_reset(17'h0ABCD, 4'd0, 1'b1);
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd0);
      measure_frame(17'h0ABCD, 4'd0, 1'b1, gap, highs, ds, de, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      total += 5;
      if (gap !== FRAME_LEN) begin bad++; $display("[TB] FAIL vol0_period: got %0d expected %0d", gap, FRAME_LEN); end
      if (ds !== e) begin bad++; $display("[TB] FAIL vol0_duty: got %0d expected %0d", ds, e); end
      if (highs !== 0) begin bad++; $display("[TB] FAIL vol0_highs: got %0d expected 0", highs); end
      if (busy !== 1'b1) begin bad++; $display("[TB] FAIL vol0_busy: got %b expected 1", busy); end
      if (sample_strobe !== 1'b1) begin bad++; $display("[TB] FAIL vol0_strobe: got %b expected 1", sample_strobe); end
      measure_frame(17'h0ABCD, 4'd0, 1'b0, gap, highs, ds, de, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      total += 2;
      if (gap !== FRAME_LEN) begin bad++; $display("[TB] FAIL vol0_period2: got %0d expected %0d", gap, FRAME_LEN); end
      if (highs !== 0 || ds !== e) begin bad++; $display("[TB] FAIL vol0_frame2: got highs=%0d duty=%0d expected highs=0 duty=%0d", highs, ds, e); end
   endtask

   // Full-scale samples with bit 16 set or clear both hit the 239 ceiling.
   task automatic test_max_duty;
      int gap, highs; logic [7:0] ds, de, e; bit ok;
      do_reset(17'h1FFFF, 4'd15, 1'b1);
      exp_q.push_back(8'd239);
      exp_q.push_back(8'd239);
      for (int f = 0; f < 2; f++) begin
         measure_frame(17'h0FFFF, 4'd15, (f == 0), gap, highs, ds, de, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         total += 3;
         if (ds !== e) begin bad++; $display("[TB] FAIL max_duty: got %0d expected %0d", ds, e); end
         if (highs !== 239 * DIV) begin bad++; $display("[TB] FAIL max_highs: got %0d expected %0d", highs, 239 * DIV); end
         if (gap !== FRAME_LEN) begin bad++; $display("[TB] FAIL max_period: got %0d expected %0d", gap, FRAME_LEN); end
      end
   endtask

   // Inputs change mid-frame; only the following frame may reflect them.
   task automatic test_random_frames;
      int gap, highs; logic [7:0] ds, de, e; bit ok;
      logic [16:0] nn; logic [3:0] nv;
      nn = 17'($urandom); nv = 4'($urandom_range(1, 15));
      do_reset(nn, nv, 1'b1);
      exp_q.push_back(model_duty(nn, nv));
      for (int f = 0; f < 4; f++) begin
         nn = 17'($urandom); nv = 4'($urandom);
         if (f < 3) exp_q.push_back(model_duty(nn, nv));
         measure_frame(nn, nv, (f < 3), gap, highs, ds, de, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         total += 4;
         if (ds !== e) begin bad++; $display("[TB] FAIL rand_duty: got %0d expected %0d", ds, e); end
         if (de !== e) begin bad++; $display("[TB] FAIL rand_duty_hold: got %0d expected %0d", de, e); end
         if (highs !== int'(e) * DIV) begin bad++; $display("[TB] FAIL rand_highs: got %0d expected %0d", highs, int'(e) * DIV); end
         if (gap !== FRAME_LEN) begin bad++; $display("[TB] FAIL rand_period: got %0d expected %0d", gap, FRAME_LEN); end
      end
   endtask

   task automatic test_enable_drop;
      int gap, highs, strobes; logic [7:0] ds, de, e; bit ok;
      do_reset(17'h08000, 4'd15, 1'b1);
      exp_q.push_back(8'd120);
      measure_frame(17'h0FFFF, 4'd15, 1'b0, gap, highs, ds, de, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      total += 4;
      if (gap !== FRAME_LEN) begin bad++; $display("[TB] FAIL drop_length: got %0d expected %0d", gap, FRAME_LEN); end
      if (highs !== 480) begin bad++; $display("[TB] FAIL drop_highs: got %0d expected 480", highs); end
      if (ds !== e) begin bad++; $display("[TB] FAIL drop_duty: got %0d expected %0d", ds, e); end
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL drop_busy: got %b expected 0", busy); end
      strobes = 0;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         strobes += int'(sample_strobe) + int'(busy) + int'(pwm_out);
      end
      total += 2;
      if (strobes !== 0) begin bad++; $display("[TB] FAIL drop_idle_activity: got %0d expected 0", strobes); end
      if (duty !== 8'd120) begin bad++; $display("[TB] FAIL drop_duty_hold: got %0d expected 120", duty); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] e;
      int n;
      do_reset(17'h08000, 4'd15, 1'b1);
      exp_q.push_back(8'd120);
      for (n = 0; n < 3000 && pwm_out !== 1'b1; n++) @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      total += 2;
      if (pwm_out !== 1'b1) begin bad++; $display("[TB] FAIL mid_wait_pwm: got %b expected 1", pwm_out); end
      if (duty !== e) begin bad++; $display("[TB] FAIL mid_duty: got %0d expected %0d", duty, e); end
      reset = 1'b1;
      @(negedge clk);
      total += 4;
      if (pwm_out !== 1'b0) begin bad++; $display("[TB] FAIL mid_pwm: got %b expected 0", pwm_out); end
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
      if (duty !== 8'd0) begin bad++; $display("[TB] FAIL mid_duty_clr: got %0d expected 0", duty); end
      if (sample_strobe !== 1'b0) begin bad++; $display("[TB] FAIL mid_strobe: got %b expected 0", sample_strobe); end
      reset = 1'b0;
      noise = 17'h0FFFF;
      exp_q.push_back(8'd239);
      @(negedge clk);
      total += 2;
      if (sample_strobe !== 1'b1) begin bad++; $display("[TB] FAIL mid_restart_strobe: got %b expected 1", sample_strobe); end
      if (pwm_out !== 1'b0) begin bad++; $display("[TB] FAIL mid_restart_pwm: got %b expected 0", pwm_out); end
      enable = 1'b0;
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      total += 2;
      if (duty !== e) begin bad++; $display("[TB] FAIL mid_restart_duty: got %0d expected %0d", duty, e); end
      if (sample_strobe !== 1'b0) begin bad++; $display("[TB] FAIL mid_strobe_single: got %b expected 0", sample_strobe); end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; noise = '0; volume = '0;
      test_reset();
      test_nominal();
      test_volume_zero();
      test_max_duty();
      test_random_frames();
      test_enable_drop();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
